mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Shares one registered 2:1 data path between two requesters, each using a valid/ready handshake.
- Arbitration is round-robin. A multi-beat packet is locked to one source until the requester signals its last beat.
- The output is a registered valid/ready channel, and the output select (`out_src`) is exported.
- Sits in front of any single-consumer resource fed by a 2:1 mux.

Parameters:
- WIDTH, 8, data width of each requester and of the output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  2  bit i = requester i has a beat
- in_last  input  2  bit i = current beat of requester i ends its packet
- in_data0  input  WIDTH  requester 0 data
- in_data1  input  WIDTH  requester 1 data
- in_ready  output  2  bit i = beat of requester i accepted this cycle (combinational)
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat
- out_data  output  WIDTH  registered muxed data
- out_last  output  1  registered last flag of the beat
- out_src  output  1  requester index of the beat in the output register
- locked  output  1  state == LOCKED

Behaviour:
Reset (rst_n low, asynchronous, any time including mid-packet):
- out_valid=0, out_data=0, out_last=0, out_src=0, locked=0.
- state=IDLE, last_grant=1, so requester 0 wins the first tie.
- A beat held in the output register at reset is discarded.
- in_ready=0 while rst_n is low.

Definitions:
- can_load = !out_valid || out_ready.
- A transfer on requester i occurs when in_valid[i] && in_ready[i] at a clock edge.
- An output transfer occurs when out_valid && out_ready.

State IDLE:
- If can_load and exactly one in_valid is set, that requester is granted.
- If both are set, the requester != last_grant is granted.
- in_ready is one-hot on the granted requester. Never both bits set.
- On the transfer edge:
  - out_data ← granted data; out_last ← in_last[g]; out_src ← g; out_valid ← 1; last_grant ← g.
  - If in_last[g]==0: state ← LOCKED, owner ← g.
- If neither is valid or !can_load: in_ready=0, no state change.

State LOCKED:
- in_ready[owner] = can_load; in_ready[!owner] = 0, regardless of its valid.
- On an owner transfer, the output register loads as in IDLE.
- If that beat has in_last=1: state ← IDLE.
- last_grant stays owner, so the other requester wins the next tie.

Output register:
- If an output transfer occurs with no new load: out_valid ← 0. out_data, out_last and out_src hold their old values.
- Simultaneous drain and load in the same cycle gives a back-to-back beat with no bubble.
- Latency from input transfer to out_valid is 1 cycle.
- Throughput is 1 beat/cycle while out_ready=1.
- While out_valid && !out_ready, all output register fields are held stable.
- in_valid deasserted mid-packet in LOCKED: the lock is held and the other requester is not serviced (no timeout).
- in_ready depends on in_valid, state, last_grant, out_valid and out_ready. There is no combinational path from in_data to in_ready.

Test Plan:
- Reset then idle: in_valid=00 for 3 cycles → out_valid=0, in_ready=00, locked=0; all outputs 0.
- Single-beat contention: in_valid=11, in_last=11, in_data0=0xA0, in_data1=0xB1, out_ready=1, held 4 cycles → out_src sequence 0,1,0,1; out_data A0,B1,A0,B1; out_valid=1 from the first edge+1 with no gaps.
- Packet lock:
  - Stimulus: requester 0 sends a 3-beat packet 0x10,0x11,0x12 (in_last only on the third beat); requester 1 valid throughout with single-beat 0x20; out_ready=1.
  - Required: out_data 10,11,12,20; locked=1 after beat 1 until the edge accepting 0x12; in_ready[1]=0 throughout the lock.
- Backpressure:
  - Stimulus: out_ready=0 with one beat 0x5A from requester 1.
  - Required: out_valid=1 and out_data=0x5A held 5 cycles; in_ready=00 during the stall.
  - Then out_ready=1 for 1 cycle → beat consumed and the next beat loaded on the same edge.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 asynchronously between clock edges during beat 2 of a requester 1 packet, with out_valid=1.
  - Required: out_valid=0, locked=0 immediately.
  - After release with in_valid=11: requester 0 granted first.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arbiter
// Brief    : Round-robin 2:1 arbiter with packet lock feeding a registered
//            valid/ready output channel. Exports the selected source.
// Revision : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       in_valid,
  input  logic [1:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  output logic [1:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  output logic             locked
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_owner;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_out_src;

  logic             w_can_load;
  logic             w_sel;
  logic [1:0]       w_ready;
  logic             w_xfer;

  // The output register can take a new beat when empty or draining this cycle.
  assign w_can_load = !r_out_valid || out_ready;

  // Grant selection, ready generation and next-state decision.
  always_comb begin
    w_ready     = 2'b00;
    w_sel       = r_owner;
    w_state_nxt = r_state;
    if (r_state == LOCKED) begin
      // Only the packet owner may proceed; its valid does not gate ready.
      w_sel          = r_owner;
      w_ready[r_owner] = w_can_load;
    end else begin
      case (in_valid)
        2'b01:   w_sel = 1'b0;
        2'b10:   w_sel = 1'b1;
        2'b11:   w_sel = ~r_last_grant;
        default: w_sel = r_owner;
      endcase
      if (w_can_load && (in_valid != 2'b00)) begin
        w_ready[w_sel] = 1'b1;
      end
    end
    w_xfer = in_valid[w_sel] && w_ready[w_sel];
    if (w_xfer) begin
      if ((r_state == IDLE) && !in_last[w_sel]) begin
        w_state_nxt = LOCKED;
      end else if ((r_state == LOCKED) && in_last[w_sel]) begin
        w_state_nxt = IDLE;
      end
    end
  end

  // Ready is forced low while reset is held so no beat is acknowledged.
  assign in_ready = rst_n ? w_ready : 2'b00;

  // Arbitration state: lock state, packet owner and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_last_grant <= w_sel;
        r_owner      <= w_sel;
      end
    end
  end

  // Output register: load on input transfer, otherwise clear valid on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel ? in_data1 : in_data0;
      r_out_last  <= in_last[w_sel];
      r_out_src   <= w_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_src   = r_out_src;
  assign locked    = (r_state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_rr_arbiter
// Brief    : Self-checking bench for mux2_rr_arbiter: directed scenarios plus
//            random traffic compared against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_valid;
  logic [1:0] in_last;
  logic [7:0] in_data0;
  logic [7:0] in_data1;
  logic [1:0] in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_src;
  logic       locked;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: output slot contents, lock owner, last-served requester.
  logic       m_ov;
  logic [7:0] m_od;
  logic       m_ol;
  logic       m_os;
  logic       m_lock;
  int         m_owner;
  int         m_last;

  mux2_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ov    = 1'b0;
    m_od    = 8'h00;
    m_ol    = 1'b0;
    m_os    = 1'b0;
    m_lock  = 1'b0;
    m_owner = 0;
    m_last  = 1;
  endfunction

  // Which requester may hand over a beat right now, as a one-hot mask.
  function automatic logic [1:0] exp_ready();
    int pick;
    if (!rst_n) return 2'b00;
    if (m_ov && !out_ready) return 2'b00;
    if (m_lock) return 2'(1 << m_owner);
    if (in_valid == 2'b00) return 2'b00;
    // Prefer whoever was not served last; fall back to the only one asking.
    pick = in_valid[1 - m_last] ? (1 - m_last) : m_last;
    return 2'(1 << pick);
  endfunction

  // Advance the model across one clock edge using the current inputs.
  function automatic void model_step();
    logic [1:0] acc;
    int g;
    acc = in_valid & exp_ready();
    if (acc != 2'b00) begin
      g      = acc[1] ? 1 : 0;
      m_ov   = 1'b1;
      m_od   = (g == 1) ? in_data1 : in_data0;
      m_ol   = in_last[g];
      m_os   = 1'(g);
      m_last = g;
      if (m_lock) begin
        if (in_last[g]) m_lock = 1'b0;
      end else if (!in_last[g]) begin
        m_lock  = 1'b1;
        m_owner = g;
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endfunction

  task automatic check_all();
    check("in_ready",  32'(in_ready),  32'(exp_ready()));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("out_last",  32'(out_last),  32'(m_ol));
    check("out_src",   32'(out_src),   32'(m_os));
    check("locked",    32'(locked),    32'(m_lock));
  endtask

  // One clock: drive on the falling edge, check, then step model at the rising edge.
  task automatic cycle(input logic [1:0] v, input logic [1:0] l,
                       input logic [7:0] d0, input logic [7:0] d1, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_last   = l;
    in_data0  = d0;
    in_data1  = d1;
    out_ready = ordy;
    #1;
    check_all();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 2'b11;
    in_last   = 2'b11;
    in_data0  = 8'h00;
    in_data1  = 8'h00;
    out_ready = 1'b1;
    model_reset();

    // Reset values, with ready gated off despite both requesters valid.
    #12;
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_locked",    32'(locked),    32'h0);
    in_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for three cycles.
    for (int i = 0; i < 3; i++) cycle(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Single-beat contention alternates 0,1,0,1.
    for (int i = 0; i < 4; i++) cycle(2'b11, 2'b11, 8'hA0, 8'hB1, 1'b1);
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Three-beat packet from requester 0 while requester 1 waits.
    cycle(2'b11, 2'b10, 8'h10, 8'h20, 1'b1);
    cycle(2'b11, 2'b10, 8'h11, 8'h20, 1'b1);
    cycle(2'b11, 2'b11, 8'h12, 8'h20, 1'b1);
    cycle(2'b10, 2'b10, 8'h00, 8'h20, 1'b1);
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Backpressure: one beat from requester 1 held while the consumer stalls.
    cycle(2'b10, 2'b10, 8'h00, 8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(2'b01, 2'b01, 8'h77, 8'h00, 1'b0);
      check("bp_hold_data", 32'(out_data), 32'h5A);
    end
    cycle(2'b01, 2'b01, 8'h77, 8'h00, 1'b1);
    #1;
    check("bp_next_data", 32'(out_data), 32'h77);
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Asynchronous reset during beat 2 of a requester 1 packet.
    cycle(2'b10, 2'b00, 8'h00, 8'hC1, 1'b1);
    @(negedge clk);
    in_valid = 2'b10;
    in_last  = 2'b00;
    in_data1 = 8'hC2;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_locked",    32'(locked),    32'h0);
    check("mid_rst_in_ready",  32'(in_ready),  32'h0);
    model_reset();
    in_valid = 2'b00;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    cycle(2'b11, 2'b11, 8'hD0, 8'hD1, 1'b1);
    #1;
    check("post_rst_first_src", 32'(out_src), 32'h0);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] v;
      logic [1:0] l;
      v    = 2'($urandom_range(0, 3));
      l[0] = ($urandom_range(0, 9) < 6);
      l[1] = ($urandom_range(0, 9) < 6);
      cycle(v, l, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
